// File: rtl/ula_seq.sv
// ============================================================================
// Module   : ula_seq
// Brief    : Registered ALU with a valid/ready handshake, status flags and an
//            optional iterative unsigned MUL/DIV (enabled by ULA_MULDIV_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module ula_seq #(
  parameter int NBITS      = 8,
  parameter bit SIGNED_SLT = 1'b1
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] result,
  output logic [NBITS-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_err
);

  localparam int SHW = $clog2(NBITS);

  localparam logic [3:0] c_OP_AND  = 4'h0;
  localparam logic [3:0] c_OP_OR   = 4'h1;
  localparam logic [3:0] c_OP_ADD  = 4'h2;
  localparam logic [3:0] c_OP_ZERO = 4'h3;
  localparam logic [3:0] c_OP_ANDN = 4'h4;
  localparam logic [3:0] c_OP_ORN  = 4'h5;
  localparam logic [3:0] c_OP_SUB  = 4'h6;
  localparam logic [3:0] c_OP_SLT  = 4'h7;
  localparam logic [3:0] c_OP_XOR  = 4'hA;
  localparam logic [3:0] c_OP_SHL  = 4'hB;
  localparam logic [3:0] c_OP_SHR  = 4'hC;

`ifdef ULA_MULDIV_EN
  localparam logic [3:0] c_OP_MUL  = 4'h8;
  localparam logic [3:0] c_OP_DIV  = 4'h9;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

  state_t r_state;

  logic [NBITS-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_err;
  logic             w_lt;
  logic [NBITS:0]   w_sum;
  logic [NBITS:0]   w_dif;

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    w_sum = {1'b0, a} + {1'b0, b};
    w_dif = {1'b0, a} - {1'b0, b};
    w_lt  = SIGNED_SLT ? ($signed(a) < $signed(b)) : (a < b);
    case (op)
      c_OP_AND:  w_res = a & b;
      c_OP_OR:   w_res = a | b;
      c_OP_ADD: begin
        w_res = w_sum[NBITS-1:0];
        w_c   = w_sum[NBITS];
        w_v   = (a[NBITS-1] == b[NBITS-1]) && (w_sum[NBITS-1] != a[NBITS-1]);
      end
      c_OP_ZERO: w_res = '0;
      c_OP_ANDN: w_res = a & ~b;
      c_OP_ORN:  w_res = a | ~b;
      c_OP_SUB: begin
        w_res = w_dif[NBITS-1:0];
        w_c   = w_dif[NBITS];
        w_v   = (a[NBITS-1] != b[NBITS-1]) && (w_dif[NBITS-1] != a[NBITS-1]);
      end
      c_OP_SLT:  w_res = {{(NBITS-1){1'b0}}, w_lt};
      c_OP_XOR:  w_res = a ^ b;
      c_OP_SHL:  w_res = a << b[SHW-1:0];
      c_OP_SHR:  w_res = a >> b[SHW-1:0];
      default:   w_err = 1'b1;
    endcase
  end

`ifdef ULA_MULDIV_EN
  // r_hi/r_lo: MUL = {partial product, multiplier}; DIV = {remainder, quotient}
  logic [NBITS-1:0] r_hi;
  logic [NBITS-1:0] r_lo;
  logic [NBITS-1:0] r_opa;
  logic [NBITS-1:0] r_opb;
  logic [SHW-1:0]   r_cnt;
  logic             r_div;
  logic [NBITS:0]   w_madd;
  logic [NBITS:0]   w_trial;
  logic [NBITS:0]   w_diff;
  logic [NBITS-1:0] w_hi_nxt;
  logic [NBITS-1:0] w_lo_nxt;

  always_comb begin
    w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opa} : {(NBITS+1){1'b0}});
    w_trial = {r_hi, r_lo[NBITS-1]};
    w_diff  = w_trial - {1'b0, r_opb};
    if (r_div) begin
      w_hi_nxt = w_diff[NBITS] ? w_trial[NBITS-1:0] : w_diff[NBITS-1:0];
      w_lo_nxt = {r_lo[NBITS-2:0], ~w_diff[NBITS]};
    end else begin
      w_hi_nxt = w_madd[NBITS:1];
      w_lo_nxt = {w_madd[0], r_lo[NBITS-1:1]};
    end
  end
`endif

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      flag_err  <= 1'b0;
`ifdef ULA_MULDIV_EN
      r_hi      <= '0;
      r_lo      <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_cnt     <= '0;
      r_div     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
`ifdef ULA_MULDIV_EN
            if (op == c_OP_MUL || op == c_OP_DIV) begin
              r_state <= S_BUSY;
              r_div   <= (op == c_OP_DIV);
              r_opa   <= a;
              r_opb   <= b;
              r_cnt   <= '0;
              r_hi    <= '0;
              r_lo    <= (op == c_OP_DIV) ? a : b;
            end else
`endif
            begin
              r_state   <= S_DONE;
              out_valid <= 1'b1;
              result    <= w_res;
              result_hi <= '0;
              flag_z    <= (w_res == '0);
              flag_n    <= w_res[NBITS-1];
              flag_c    <= w_c;
              flag_v    <= w_v;
              flag_err  <= w_err;
            end
          end
        end
`ifdef ULA_MULDIV_EN
        S_BUSY: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == SHW'(NBITS-1)) begin
            r_state   <= S_DONE;
            out_valid <= 1'b1;
            result    <= w_lo_nxt;
            result_hi <= w_hi_nxt;
            flag_z    <= r_div ? (w_lo_nxt == '0) : ({w_hi_nxt, w_lo_nxt} == '0);
            flag_n    <= w_lo_nxt[NBITS-1];
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_err  <= r_div && (r_opb == '0);
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ula_seq.sv
// ============================================================================
// Module   : tb_ula_seq
// Brief    : Directed vector bench for ula_seq (NBITS=8, SIGNED_SLT=1);
//            expectations follow ULA_MULDIV_EN when it is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ula_seq;

  logic       clk_2;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic       flag_z;
  logic       flag_n;
  logic       flag_c;
  logic       flag_v;
  logic       flag_err;

  int n_cmp = 0;
  int n_bad = 0;

  ula_seq #(.NBITS(8), .SIGNED_SLT(1'b1)) dut (
    .clk_2     (clk_2),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_err  (flag_err)
  );

  initial begin
    clk_2 = 1'b0;
    forever #5 clk_2 = ~clk_2;
  end

  // fl packs {z, n, c, v, err}
  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] hi;
    logic [4:0] fl;
    int         lat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic [3:0] o, input logic [7:0] va,
                     input logic [7:0] vb, input logic [7:0] r, input logic [7:0] h,
                     input logic [4:0] f, input int l);
    vec_t v;
    v.name = nm; v.op = o; v.a = va; v.b = vb; v.res = r; v.hi = h; v.fl = f; v.lat = l;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk_2);
    chk({v.name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    op = v.op; a = v.a; b = v.b; in_valid = 1'b1;
    @(posedge clk_2);
    #1;
    in_valid = 1'b0; a = ~v.a; b = ~v.b; op = ~v.op;
    lat = 0;
    do begin
      @(negedge clk_2);
      lat++;
      if (!out_valid) chk({v.name, "_busy_ready"}, {31'd0, in_ready}, 32'd0);
    end while (!out_valid && lat < 40);
    chk({v.name, "_latency"}, lat, v.lat);
    chk({v.name, "_result"}, {24'd0, result}, {24'd0, v.res});
    chk({v.name, "_result_hi"}, {24'd0, result_hi}, {24'd0, v.hi});
    chk({v.name, "_flags"}, {27'd0, flag_z, flag_n, flag_c, flag_v, flag_err}, {27'd0, v.fl});
    out_ready = 1'b1;
    @(posedge clk_2);
    #1;
    out_ready = 1'b0;
    chk({v.name, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int  seen;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;

    //   name      op     a      b      res    hi     zncve     lat
    add("and",  4'h0, 8'hF0, 8'h3C, 8'h30, 8'h00, 5'b00000, 1);
    add("or",   4'h1, 8'hA0, 8'h05, 8'hA5, 8'h00, 5'b01000, 1);
    add("add_v",4'h2, 8'h7F, 8'h01, 8'h80, 8'h00, 5'b01010, 1);
    add("add_c",4'h2, 8'hFF, 8'h01, 8'h00, 8'h00, 5'b10100, 1);
    add("zero", 4'h3, 8'h12, 8'h34, 8'h00, 8'h00, 5'b10000, 1);
    add("andn", 4'h4, 8'hFF, 8'h0F, 8'hF0, 8'h00, 5'b01000, 1);
    add("orn",  4'h5, 8'h00, 8'h0F, 8'hF0, 8'h00, 5'b01000, 1);
    add("sub_b",4'h6, 8'h03, 8'h05, 8'hFE, 8'h00, 5'b01100, 1);
    add("sub_v",4'h6, 8'h80, 8'h01, 8'h7F, 8'h00, 5'b00010, 1);
    add("slt_1",4'h7, 8'hFE, 8'h01, 8'h01, 8'h00, 5'b00000, 1);
    add("slt_0",4'h7, 8'h01, 8'hFE, 8'h00, 8'h00, 5'b10000, 1);
    add("xor",  4'hA, 8'hAA, 8'h55, 8'hFF, 8'h00, 5'b01000, 1);
    add("shl",  4'hB, 8'h81, 8'h0B, 8'h08, 8'h00, 5'b00000, 1);
    add("shr",  4'hC, 8'h81, 8'h07, 8'h01, 8'h00, 5'b00000, 1);
    add("rsv_d",4'hD, 8'h12, 8'h34, 8'h00, 8'h00, 5'b10001, 1);
    add("rsv_f",4'hF, 8'hFF, 8'hFF, 8'h00, 8'h00, 5'b10001, 1);
`ifdef ULA_MULDIV_EN
    add("mul_ff",4'h8, 8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b00000, 9);
    add("mul_0", 4'h8, 8'h00, 8'h55, 8'h00, 8'h00, 5'b10000, 9);
    add("mul_2", 4'h8, 8'h10, 8'h10, 8'h00, 8'h01, 5'b00000, 9);
    add("div",   4'h9, 8'd100,8'd7,  8'd14, 8'd2,  5'b00000, 9);
    add("div_0", 4'h9, 8'd100,8'd0,  8'hFF, 8'd100,5'b01001, 9);
`else
    add("mul_rsv",4'h8, 8'hFF, 8'hFF, 8'h00, 8'h00, 5'b10001, 1);
    add("div_rsv",4'h9, 8'd100,8'd7,  8'h00, 8'h00, 5'b10001, 1);
`endif

    #12;
    chk("reset_state", {22'd0, in_ready, out_valid, result, result_hi, flag_z, flag_n,
        flag_c, flag_v, flag_err}, {22'd0, 1'b1, 1'b0, 8'h00, 8'h00, 5'b00000});
    @(negedge clk_2);
    reset_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset in the middle of a MUL discards it
    @(negedge clk_2);
    op = 4'h8; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk_2);
    #1;
    in_valid = 1'b0;
    @(negedge clk_2);
    @(negedge clk_2);
    reset_n = 1'b0;
    #1;
    chk("midop_reset", {22'd0, in_ready, out_valid, result, result_hi, flag_z, flag_n,
        flag_c, flag_v, flag_err}, {22'd0, 1'b1, 1'b0, 8'h00, 8'h00, 5'b00000});
    @(negedge clk_2);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_2);
      if (out_valid) seen++;
    end
    chk("midop_no_result", seen, 0);

    // Backpressure: result held, new requests ignored while DONE
    @(negedge clk_2);
    op = 4'hA; a = 8'hAA; b = 8'h55; in_valid = 1'b1;
    @(posedge clk_2);
    #1;
    op = 4'h2; a = 8'h01; b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_2);
      chk("bp_hold", {22'd0, out_valid, in_ready, result}, {22'd0, 1'b1, 1'b0, 8'hFF});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk_2);
    #1;
    out_ready = 1'b0;
    chk("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_2);
      if (out_valid) seen++;
    end
    chk("bp_no_ghost", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
